// File: rtl/cu_decode_queue.sv
// RV32I(+M) control unit decoding at enqueue into an in-order FIFO of control bundles.
// imm_type: 0 NOP,1 R,2 I,3 S,4 B,5 U,6 J; dmem_mode: 0 byte,1 half,2 word.
module cu_decode_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [2:0]          imm_type,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [1:0]          dmem_mode,
  output logic                dmem_unsigned,
  output logic                rf_write,
  output logic                rs1_pc_sel,
  output logic                rs2_imm_sel,
  output logic                wb_dmem_sel,
  output logic                branch,
  output logic                jump,
  output logic                jalr,
  output logic                muldiv,
  output logic [2:0]          muldiv_op,
  output logic                illegal
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    NOP_TYPE, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } imm_sel_e;

  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_mode_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    imm_sel_e  imm_type;
    logic      dmem_read;
    logic      dmem_write;
    mem_mode_e dmem_mode;
    logic      dmem_unsigned;
    logic      rf_write;
    logic      rs1_pc_sel;
    logic      rs2_imm_sel;
    logic      wb_dmem_sel;
    logic      branch;
    logic      jump;
    logic      jalr;
    logic      muldiv;
    logic [2:0] muldiv_op;
    logic      illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    ctrl_t               ctrl;
  } entry_t;

  localparam ctrl_t CTRL_NOP = '0;

  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec;

  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    dec = CTRL_NOP;
    case (in_instr[6:0])
      OPC_LUI: begin
        dec.imm_type = U_TYPE; dec.rf_write = 1'b1; dec.rs2_imm_sel = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm_type = U_TYPE; dec.rf_write = 1'b1; dec.rs2_imm_sel = 1'b1;
        dec.rs1_pc_sel = 1'b1;
      end
      OPC_JAL: begin
        dec.imm_type = J_TYPE; dec.rf_write = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          dec.imm_type = I_TYPE; dec.rf_write = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          dec.imm_type = B_TYPE; dec.branch = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          dec.imm_type    = I_TYPE;
          dec.rs2_imm_sel = 1'b1;
          dec.wb_dmem_sel = 1'b1;
          dec.dmem_read   = 1'b1;
          dec.rf_write    = 1'b1;
          dec.dmem_mode   = mem_mode_e'(f3[1:0]);
          dec.dmem_unsigned = f3[2];
        end else dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        if (f3 inside {3'b000, 3'b001, 3'b010}) begin
          dec.imm_type    = S_TYPE;
          dec.rs2_imm_sel = 1'b1;
          dec.dmem_write  = 1'b1;
          dec.dmem_mode   = mem_mode_e'(f3[1:0]);
        end else dec.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        // shifts carry funct7 in the immediate; only SRAI may set bit 30
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.imm_type = I_TYPE; dec.rf_write = 1'b1; dec.rs2_imm_sel = 1'b1;
        end
      end
      OPC_OP: begin
        if (f7 == 7'b0000001) begin
          if (ENABLE_M) begin
            dec.imm_type = R_TYPE; dec.rf_write = 1'b1;
            dec.muldiv = 1'b1; dec.muldiv_op = f3;
          end else dec.illegal = 1'b1;
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.imm_type = R_TYPE; dec.rf_write = 1'b1;
        end else dec.illegal = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: dec = CTRL_NOP;
      default: dec.illegal = 1'b1;
    endcase
  end

  entry_t             mem [DEPTH];
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;
  entry_t             head;

  assign in_ready  = !rst && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc, ctrl: dec};
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_instr     = head.instr;
  assign out_pc        = head.pc;
  assign imm_type      = head.ctrl.imm_type;
  assign dmem_read     = head.ctrl.dmem_read;
  assign dmem_write    = head.ctrl.dmem_write;
  assign dmem_mode     = head.ctrl.dmem_mode;
  assign dmem_unsigned = head.ctrl.dmem_unsigned;
  assign rf_write      = head.ctrl.rf_write;
  assign rs1_pc_sel    = head.ctrl.rs1_pc_sel;
  assign rs2_imm_sel   = head.ctrl.rs2_imm_sel;
  assign wb_dmem_sel   = head.ctrl.wb_dmem_sel;
  assign branch        = head.ctrl.branch;
  assign jump          = head.ctrl.jump;
  assign jalr          = head.ctrl.jalr;
  assign muldiv        = head.ctrl.muldiv;
  assign muldiv_op     = head.ctrl.muldiv_op;
  assign illegal       = head.ctrl.illegal;
endmodule
